// File: rtl/demultiplex_queue_pkg.sv
// Width helpers for the demultiplexing queue: select width and per-channel
// FIFO pointer/count widths, all derived from the top-level parameters.
package demultiplex_queue_pkg;

    function automatic int sel_width(input int outc, input int bcast);
        return (bcast != 0) ? outc : $clog2(outc);
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/demultiplex_queue_queue.sv
// Per-channel synchronous FIFO: combinational head read, power-of-two depth,
// pointers and count cleared by reset while storage keeps its contents.
module demultiplex_queue_queue
    import demultiplex_queue_pkg::*;
#(
    parameter int ARGW  = 16,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [ARGW-1:0] push_dat,
    input  logic            pop,
    output logic            empty,
    output logic            full,
    output logic [ARGW-1:0] head_dat
);

    localparam int PTRW = ptr_width(DEPTH);
    localparam int CNTW = cnt_width(DEPTH);

    logic [ARGW-1:0] mem_q [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            pop_ok;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNTW'(DEPTH));
    assign pop_ok   = pop & ~empty;
    assign head_dat = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTRW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        case ({push, pop_ok})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/demultiplex_queue.sv
// Routes each arg word to one channel (index) or several (mask) through
// independent per-channel FIFOs; a broadcast is accepted only if all targets have room.
module demultiplex_queue
    import demultiplex_queue_pkg::*;
#(
    parameter int ARGW  = 16,
    parameter int OUTC  = 4,
    parameter int DEPTH = 2,
    parameter int BCAST = 0,
    localparam int SELW = sel_width(OUTC, BCAST)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arg_stb,
    input  logic [ARGW-1:0]      arg_dat,
    output logic                 arg_rdy,
    input  logic                 sel_stb,
    input  logic [SELW-1:0]      sel_dat,
    output logic                 sel_rdy,
    output logic [OUTC-1:0]      out_stb,
    output logic [OUTC*ARGW-1:0] out_dat,
    input  logic [OUTC-1:0]      out_rdy,
    output logic                 drop
);

    logic [OUTC-1:0] tgt;
    logic [OUTC-1:0] empty;
    logic [OUTC-1:0] full;
    logic [OUTC-1:0] space;
    logic [OUTC-1:0] push;
    logic [OUTC-1:0] pop;
    logic            drop_q;

    for (genvar gi = 0; gi < OUTC; gi++) begin : g_ch
        if (BCAST != 0) begin : g_mask
            assign tgt[gi] = sel_dat[gi];
        end else begin : g_idx
            // Out-of-range indices match no channel and become drops.
            assign tgt[gi] = (sel_dat == SELW'(gi));
        end

        assign space[gi]   = ~full[gi] | (~empty[gi] & out_rdy[gi]);
        assign pop[gi]     = out_rdy[gi] & ~empty[gi];
        assign push[gi]    = arg_rdy & tgt[gi];
        assign out_stb[gi] = ~empty[gi];

        demultiplex_queue_queue #(
            .ARGW  (ARGW),
            .DEPTH (DEPTH)
        ) u_queue (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push[gi]),
            .push_dat (arg_dat),
            .pop      (pop[gi]),
            .empty    (empty[gi]),
            .full     (full[gi]),
            .head_dat (out_dat[ARGW*gi +: ARGW])
        );
    end

    assign arg_rdy = rst_n & arg_stb & sel_stb & ~|(tgt & ~space);
    assign sel_rdy = arg_rdy;
    assign drop    = drop_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= arg_rdy & ~|tgt;
        end
    end

endmodule

// File: tb/tb_demultiplex_queue.sv
// Bench for demultiplex_queue: index mode (4 and 3 channels) and mask mode,
// checked every cycle against a queue model plus directed literal expectations.
module tb_demultiplex_queue;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_arg_stb = 0, a_sel_stb = 0, a_arg_rdy, a_sel_rdy, a_drop;
    logic [15:0] a_arg_dat = 0;
    logic [1:0]  a_sel_dat = 0;
    logic [3:0]  a_out_stb, a_out_rdy = 0;
    logic [63:0] a_out_dat;

    logic        b_arg_stb = 0, b_sel_stb = 0, b_arg_rdy, b_sel_rdy, b_drop;
    logic [15:0] b_arg_dat = 0;
    logic [3:0]  b_sel_dat = 0;
    logic [3:0]  b_out_stb, b_out_rdy = 0;
    logic [63:0] b_out_dat;

    logic        c_arg_stb = 0, c_sel_stb = 0, c_arg_rdy, c_sel_rdy, c_drop;
    logic [15:0] c_arg_dat = 0;
    logic [1:0]  c_sel_dat = 0;
    logic [2:0]  c_out_stb, c_out_rdy = 0;
    logic [47:0] c_out_dat;

    demultiplex_queue #(.ARGW(16), .OUTC(4), .DEPTH(DEPTH), .BCAST(0)) u_a (
        .clk(clk), .rst_n(rst_n), .arg_stb(a_arg_stb), .arg_dat(a_arg_dat), .arg_rdy(a_arg_rdy),
        .sel_stb(a_sel_stb), .sel_dat(a_sel_dat), .sel_rdy(a_sel_rdy), .out_stb(a_out_stb),
        .out_dat(a_out_dat), .out_rdy(a_out_rdy), .drop(a_drop));

    demultiplex_queue #(.ARGW(16), .OUTC(4), .DEPTH(DEPTH), .BCAST(1)) u_b (
        .clk(clk), .rst_n(rst_n), .arg_stb(b_arg_stb), .arg_dat(b_arg_dat), .arg_rdy(b_arg_rdy),
        .sel_stb(b_sel_stb), .sel_dat(b_sel_dat), .sel_rdy(b_sel_rdy), .out_stb(b_out_stb),
        .out_dat(b_out_dat), .out_rdy(b_out_rdy), .drop(b_drop));

    demultiplex_queue #(.ARGW(16), .OUTC(3), .DEPTH(DEPTH), .BCAST(0)) u_c (
        .clk(clk), .rst_n(rst_n), .arg_stb(c_arg_stb), .arg_dat(c_arg_dat), .arg_rdy(c_arg_rdy),
        .sel_stb(c_sel_stb), .sel_dat(c_sel_dat), .sel_rdy(c_sel_rdy), .out_stb(c_out_stb),
        .out_dat(c_out_dat), .out_rdy(c_out_rdy), .drop(c_drop));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Accessors that let the model treat the three instances uniformly.
    function automatic int outc(input int k);
        return (k == 2) ? 3 : 4;
    endfunction
    function automatic logic both_stb(input int k);
        case (k)
            0: return a_arg_stb & a_sel_stb;
            1: return b_arg_stb & b_sel_stb;
            default: return c_arg_stb & c_sel_stb;
        endcase
    endfunction
    function automatic int in_sel(input int k);
        case (k)
            0: return int'(a_sel_dat);
            1: return int'(b_sel_dat);
            default: return int'(c_sel_dat);
        endcase
    endfunction
    function automatic logic [15:0] in_dat(input int k);
        case (k)
            0: return a_arg_dat;
            1: return b_arg_dat;
            default: return c_arg_dat;
        endcase
    endfunction
    function automatic logic in_ordy(input int k, input int ch);
        case (k)
            0: return a_out_rdy[ch];
            1: return b_out_rdy[ch];
            default: return c_out_rdy[ch];
        endcase
    endfunction
    function automatic logic [1:0] dut_rdy(input int k);
        case (k)
            0: return {a_arg_rdy, a_sel_rdy};
            1: return {b_arg_rdy, b_sel_rdy};
            default: return {c_arg_rdy, c_sel_rdy};
        endcase
    endfunction
    function automatic logic dut_stb(input int k, input int ch);
        case (k)
            0: return a_out_stb[ch];
            1: return b_out_stb[ch];
            default: return c_out_stb[ch];
        endcase
    endfunction
    function automatic logic [15:0] dut_dat(input int k, input int ch);
        case (k)
            0: return a_out_dat[16*ch +: 16];
            1: return b_out_dat[16*ch +: 16];
            default: return c_out_dat[16*ch +: 16];
        endcase
    endfunction
    function automatic logic dut_drop(input int k);
        case (k)
            0: return a_drop;
            1: return b_drop;
            default: return c_drop;
        endcase
    endfunction

    // Instance 1 decodes a mask, the others a plain channel index.
    function automatic logic [3:0] target(input int k, input int sel);
        logic [3:0] t;
        t = '0;
        if (k == 1) t = sel[3:0];
        else if (sel < outc(k)) t[sel] = 1'b1;
        return t;
    endfunction

    int          m_cnt [3][4];
    logic [15:0] m_q   [3][4][DEPTH];
    bit          m_drop[3];
    bit          m_on = 0;

    function automatic logic model_rdy(input int k);
        logic [3:0] t;
        if (!rst_n || !both_stb(k)) return 1'b0;
        t = target(k, in_sel(k));
        for (int ch = 0; ch < outc(k); ch++) begin
            if (t[ch] && !(m_cnt[k][ch] < DEPTH || (m_cnt[k][ch] > 0 && in_ordy(k, ch))))
                return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        logic       exp_rdy;
        logic [3:0] t;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                exp_rdy = model_rdy(k);
                if (m_on) begin
                    chk($sformatf("rdy[%0d]", k), 32'(dut_rdy(k)), 32'({exp_rdy, exp_rdy}));
                    chk($sformatf("drop[%0d]", k), 32'(dut_drop(k)), 32'(m_drop[k]));
                    for (int ch = 0; ch < outc(k); ch++) begin
                        chk($sformatf("stb[%0d][%0d]", k, ch), 32'(dut_stb(k, ch)), 32'(m_cnt[k][ch] > 0));
                        if (m_cnt[k][ch] > 0)
                            chk($sformatf("dat[%0d][%0d]", k, ch), 32'(dut_dat(k, ch)), 32'(m_q[k][ch][0]));
                    end
                end
                if (!rst_n) begin
                    for (int ch = 0; ch < 4; ch++) m_cnt[k][ch] = 0;
                    m_drop[k] = 0;
                end else begin
                    t = target(k, in_sel(k));
                    for (int ch = 0; ch < outc(k); ch++) begin
                        if (m_cnt[k][ch] > 0 && in_ordy(k, ch)) begin
                            for (int j = 0; j < DEPTH - 1; j++) m_q[k][ch][j] = m_q[k][ch][j+1];
                            m_cnt[k][ch]--;
                        end
                        if (exp_rdy && t[ch]) begin
                            m_q[k][ch][m_cnt[k][ch]] = in_dat(k);
                            m_cnt[k][ch]++;
                        end
                    end
                    m_drop[k] = exp_rdy && (t == 4'd0);
                end
            end
        end
    end

    task automatic drive(input int k, input logic s, input logic [3:0] sel, input logic [15:0] d);
        case (k)
            0: begin a_arg_stb = s; a_sel_stb = s; a_sel_dat = sel[1:0]; a_arg_dat = d; end
            1: begin b_arg_stb = s; b_sel_stb = s; b_sel_dat = sel;      b_arg_dat = d; end
            default: begin c_arg_stb = s; c_sel_stb = s; c_sel_dat = sel[1:0]; c_arg_dat = d; end
        endcase
    endtask

    task automatic ordy(input int k, input logic [3:0] m);
        case (k)
            0: a_out_rdy = m;
            1: b_out_rdy = m;
            default: c_out_rdy = m[2:0];
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, with strobes raised to confirm ready is gated.
        tick(); tick();
        drive(0, 1, 4'd0, 16'h0005);
        #1 chk("reset_rdy_gated", 32'(a_arg_rdy), 32'd0);
        drive(0, 0, 4'd0, 16'h0);
        chk("reset_stb_a", 32'(a_out_stb), 32'd0);
        chk("reset_stb_b", 32'(b_out_stb), 32'd0);
        chk("reset_stb_c", 32'(c_out_stb), 32'd0);
        chk("reset_drop", 32'({a_drop, b_drop, c_drop}), 32'd0);
        tick();
        rst_n = 1'b1;
        m_on  = 1;

        // Single word to channel 2.
        ordy(0, 4'hF);
        drive(0, 1, 4'd2, 16'h1111);
        #1 chk("t1_rdy", 32'(a_arg_rdy), 32'd1);
        tick(); drive(0, 0, 4'd0, 16'h0);
        #1 chk("t1_stb", 32'(a_out_stb), 32'b0100);
        chk("t1_dat", 32'(a_out_dat[47:32]), 32'h1111);
        tick();
        chk("t1_stb_after", 32'(a_out_stb), 32'b0000);

        // Channel 1 stalled: third word blocks, channel 3 still flows.
        ordy(0, 4'b1101);
        drive(0, 1, 4'd1, 16'h000A); #1 chk("t2_rdy_a", 32'(a_arg_rdy), 32'd1); tick();
        drive(0, 1, 4'd1, 16'h000B); #1 chk("t2_rdy_b", 32'(a_arg_rdy), 32'd1); tick();
        drive(0, 1, 4'd1, 16'h000C); #1 chk("t2_rdy_c", 32'(a_arg_rdy), 32'd0); tick();
        drive(0, 1, 4'd3, 16'h000D); #1 chk("t2_rdy_d", 32'(a_arg_rdy), 32'd1); tick();
        drive(0, 0, 4'd0, 16'h0);
        #1 chk("t2_stb", 32'(a_out_stb), 32'b1010);
        chk("t2_dat3", 32'(a_out_dat[63:48]), 32'h000D);
        tick();
        chk("t2_stb2", 32'(a_out_stb), 32'b0010);
        chk("t2_head1", 32'(a_out_dat[31:16]), 32'h000A);
        ordy(0, 4'hF); tick();
        chk("t2_head1b", 32'(a_out_dat[31:16]), 32'h000B);
        tick();
        chk("t2_empty", 32'(a_out_stb), 32'd0);

        // Full channel 0 accepts a push in the cycle it is popped.
        ordy(0, 4'b1110);
        drive(0, 1, 4'd0, 16'h0021); tick();
        drive(0, 1, 4'd0, 16'h0022); tick();
        drive(0, 1, 4'd0, 16'h0023);
        #1 chk("t3_full_rdy", 32'(a_arg_rdy), 32'd0);
        ordy(0, 4'hF);
        #1 chk("t3_pop_rdy", 32'(a_arg_rdy), 32'd1);
        tick(); drive(0, 0, 4'd0, 16'h0); ordy(0, 4'h0);
        #1 chk("t3_stb", 32'(a_out_stb), 32'b0001);
        chk("t3_head", 32'(a_out_dat[15:0]), 32'h0022);
        ordy(0, 4'h1); tick();
        chk("t3_head2", 32'(a_out_dat[15:0]), 32'h0023);
        chk("t3_stb2", 32'(a_out_stb), 32'b0001);
        tick();
        chk("t3_empty", 32'(a_out_stb), 32'd0);

        // Broadcast blocked by full channel 3, then all-or-nothing accept.
        ordy(1, 4'b0111);
        drive(1, 1, 4'b1000, 16'h0031); tick();
        drive(1, 1, 4'b1000, 16'h0032); tick();
        drive(1, 1, 4'b1010, 16'h0055);
        #1 chk("t4_blocked", 32'(b_arg_rdy), 32'd0);
        tick();
        chk("t4_no_partial", 32'(b_out_stb), 32'b1000);
        ordy(1, 4'b1000);
        #1 chk("t4_rdy", 32'(b_arg_rdy), 32'd1);
        tick(); drive(1, 0, 4'd0, 16'h0); ordy(1, 4'h0);
        #1 chk("t4_stb", 32'(b_out_stb), 32'b1010);
        chk("t4_dat1", 32'(b_out_dat[31:16]), 32'h0055);
        chk("t4_dat3", 32'(b_out_dat[63:48]), 32'h0032);
        ordy(1, 4'b1000); tick();
        chk("t4_dat3b", 32'(b_out_dat[63:48]), 32'h0055);
        ordy(1, 4'hF); tick();
        chk("t4_drained", 32'(b_out_stb), 32'd0);
        drive(1, 1, 4'b0000, 16'h0066);
        #1 chk("t4_empty_mask_rdy", 32'(b_arg_rdy), 32'd1);
        tick(); drive(1, 0, 4'd0, 16'h0);
        #1 chk("t4_drop", 32'(b_drop), 32'd1);
        chk("t4_drop_stb", 32'(b_out_stb), 32'd0);
        tick();
        chk("t4_drop_once", 32'(b_drop), 32'd0);

        // Out-of-range index on a 3-channel instance.
        ordy(2, 4'h0);
        drive(2, 1, 4'd1, 16'h0071); tick();
        drive(2, 1, 4'd3, 16'h0077);
        #1 chk("t5_rdy", 32'(c_arg_rdy), 32'd1);
        tick(); drive(2, 0, 4'd0, 16'h0);
        #1 chk("t5_drop", 32'(c_drop), 32'd1);
        chk("t5_stb", 32'(c_out_stb), 32'b010);
        tick();
        chk("t5_drop_once", 32'(c_drop), 32'd0);
        ordy(2, 4'h7); tick();

        // Mid-operation reset discards queued words.
        ordy(0, 4'h0);
        drive(0, 1, 4'd0, 16'h0040); tick();
        drive(0, 1, 4'd0, 16'h0041); tick();
        drive(0, 1, 4'd2, 16'h0042); tick();
        drive(0, 1, 4'd2, 16'h0043); tick();
        drive(0, 1, 4'd0, 16'h00EE);
        chk("t6_loaded", 32'(a_out_stb), 32'b0101);
        rst_n = 1'b0;
        #1 chk("t6_rdy_gated", 32'(a_arg_rdy), 32'd0);
        tick(); rst_n = 1'b1; drive(0, 0, 4'd0, 16'h0);
        #1 chk("t6_cleared", 32'(a_out_stb), 32'd0);
        drive(0, 1, 4'd0, 16'h0099); tick(); drive(0, 0, 4'd0, 16'h0);
        #1 chk("t6_one_word", 32'(a_out_stb), 32'b0001);
        chk("t6_dat", 32'(a_out_dat[15:0]), 32'h0099);
        ordy(0, 4'h1); tick();
        chk("t6_exactly_one", 32'(a_out_stb), 32'd0);

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
